// File: rtl/vga_timing_gen_pkg.sv
// Shared types and the default 640x480@60 Hz timing set for the VGA raster generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_CW       = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator (master) to pixel/fetch consumers (slave).
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;
  logic          fetch_active;

  modport master (
    output hsync, vsync, active, x, y, line_start, frame_start,
    output fetch_x, fetch_y, fetch_active
  );

  modport slave (
    input hsync, vsync, active, x, y, line_start, frame_start,
    input fetch_x, fetch_y, fetch_active
  );
endinterface

// File: rtl/vga_sync_axis.sv
// One raster axis: wrapping counter with carry-out plus active and sync window decodes.
module vga_sync_axis #(
  parameter int CW       = 10,
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output logic          carry_o,
  output logic          act_o,
  output logic          sync_o
);

  localparam int            TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_LIM = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_s;

  // Next count: advance on enable, wrap after the last position of the axis.
  always_comb begin
    last_s = (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (adv_i) begin
      if (last_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign carry_o = adv_i & last_s;
  assign act_o   = (cnt_q < ACT_LIM);
  assign sync_o  = (cnt_q >= SYNC_LO) && (cnt_q <= SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, one-pixel registered outputs, line/frame strobes
// and an early fetch coordinate for 1-cycle-latency memory reads.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  vga_timing_gen_if.master vga
);

  localparam int   H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic SYNC_ON   = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (H_TOTAL > (2 ** CW)) begin : g_h_range_err
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (V_TOTAL > (2 ** CW)) begin : g_v_range_err
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end

  logic [CW-1:0] hcnt_s;
  logic [CW-1:0] vcnt_s;
  logic          h_carry_s;
  logic          v_carry_unused_s;
  logic          h_act_s;
  logic          v_act_s;
  logic          hs0_s;
  logic          vs0_s;
  logic          act0_s;

  vga_sync_axis #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(pix_en),
    .cnt_o(hcnt_s), .carry_o(h_carry_s), .act_o(h_act_s), .sync_o(hs0_s)
  );

  // The vertical axis only moves when the horizontal axis wraps.
  vga_sync_axis #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(h_carry_s),
    .cnt_o(vcnt_s), .carry_o(v_carry_unused_s), .act_o(v_act_s), .sync_o(vs0_s)
  );

  assign act0_s = h_act_s & v_act_s;

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Stage-1 next values; strobes are recomputed every clk so they last one cycle at any pix_en rate.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      x_d           = hcnt_s;
      y_d           = vcnt_s;
      active_d      = act0_s;
      hsync_d       = hs0_s ? SYNC_ON : SYNC_IDLE;
      vsync_d       = vs0_s ? SYNC_ON : SYNC_IDLE;
      line_start_d  = (hcnt_s == {CW{1'b0}});
      frame_start_d = (hcnt_s == {CW{1'b0}}) && (vcnt_s == {CW{1'b0}});
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // Stage-1 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= {CW{1'b0}};
      y_q           <= {CW{1'b0}};
      active_q      <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.x            = x_q;
  assign vga.y            = y_q;
  assign vga.active       = active_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.line_start   = line_start_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.fetch_x      = hcnt_s;
  assign vga.fetch_y      = vcnt_s;
  assign vga.fetch_active = act0_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, a shrunken instance for frame timing.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
  } tp_t;

  typedef struct {
    logic pe;
    int   x;
    int   y;
    logic ls;
    logic fs;
    int   fx;
    logic fact;
    logic hs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pe0 = 1'b0;
  logic pe1 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tp_t  tp[2];
  int   mh[2];
  int   mv[2];
  obs_t held[2];
  obs_t sb0[$];
  obs_t sb1[$];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(10)) if0 ();
  vga_timing_gen_if #(.CW(10)) if1 ();

  vga_timing_gen dut0 (.clk(clk), .rst_n(rst_n), .pix_en(pe0), .vga(if0));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut1 (.clk(clk), .rst_n(rst_n), .pix_en(pe1), .vga(if1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.x = if0.x; o.y = if0.y; o.act = if0.active; o.hs = if0.hsync;
      o.vs = if0.vsync; o.ls = if0.line_start; o.fs = if0.frame_start;
    end else begin
      o.x = if1.x; o.y = if1.y; o.act = if1.active; o.hs = if1.hsync;
      o.vs = if1.vsync; o.ls = if1.line_start; o.fs = if1.frame_start;
    end
    return o;
  endfunction

  function automatic logic [20:0] get_fetch(input int d);
    if (d == 0) return {if0.fetch_x, if0.fetch_y, if0.fetch_active};
    else        return {if1.fetch_x, if1.fetch_y, if1.fetch_active};
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.x = 10'd0; o.y = 10'd0; o.act = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.ls = 1'b0; o.fs = 1'b0;
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mh[d] = 0; mv[d] = 0; held[d] = reset_obs();
    end
    sb0.delete(); sb1.delete();
  endtask

  // Reference raster model: expected registered outputs after one clk with the given enable.
  task automatic model_step(input int d, input logic pe, output obs_t e);
    int ht, vt, hlo, vlo;
    ht  = tp[d].ha + tp[d].hf + tp[d].hs + tp[d].hb;
    vt  = tp[d].va + tp[d].vf + tp[d].vs + tp[d].vb;
    hlo = tp[d].ha + tp[d].hf;
    vlo = tp[d].va + tp[d].vf;
    e = held[d];
    e.ls = 1'b0;
    e.fs = 1'b0;
    if (pe) begin
      e.x   = 10'(mh[d]);
      e.y   = 10'(mv[d]);
      e.act = (mh[d] < tp[d].ha) && (mv[d] < tp[d].va);
      e.hs  = !((mh[d] >= hlo) && (mh[d] < hlo + tp[d].hs));
      e.vs  = !((mv[d] >= vlo) && (mv[d] < vlo + tp[d].vs));
      e.ls  = (mh[d] == 0);
      e.fs  = (mh[d] == 0) && (mv[d] == 0);
      mh[d]++;
      if (mh[d] == ht) begin
        mh[d] = 0;
        mv[d]++;
        if (mv[d] == vt) mv[d] = 0;
      end
    end
    held[d] = e;
  endtask

  task automatic tick(input logic p0, input logic p1);
    obs_t e;
    logic [20:0] pf[2];
    logic pe[2];
    pe[0] = p0; pe[1] = p1;
    for (int d = 0; d < 2; d++) begin
      pf[d] = get_fetch(d);
      model_step(d, pe[d], e);
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    pe0 = p0;
    pe1 = p1;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      obs_t o;
      o = get_obs(d);
      if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
      check(d == 0 ? "regs0" : "regs1", 64'(o), 64'(e));
      check(d == 0 ? "fetch0" : "fetch1", 64'(get_fetch(d)),
            64'({10'(mh[d]), 10'(mv[d]), (mh[d] < tp[d].ha) && (mv[d] < tp[d].va)}));
      if (pe[d]) begin
        check(d == 0 ? "align0" : "align1", 64'({o.x, o.y, o.act}), 64'(pf[d]));
      end
    end
  endtask

  vec_t vt[6];
  int   hs_low, act_cnt, first_lo, last_lo, ls_at, ls_cnt, vs_low, fs_at;
  int   fs_prev, fs_events, k;
  logic ok;
  obs_t prev, cur;

  initial begin
    tp[0] = '{DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
              DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP};
    tp[1] = '{8, 2, 3, 3, 6, 2, 2, 2};
    vt[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
    vt[1] = '{1'b1, 1, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1};
    vt[2] = '{1'b0, 1, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1};
    vt[4] = '{1'b1, 2, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1};
    vt[5] = '{1'b1, 3, 0, 1'b0, 1'b0, 4, 1'b1, 1'b1};
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", 64'(get_obs(0)), 64'(reset_obs()));
    check("reset_fetch", 64'(get_fetch(0)), 64'({10'd0, 10'd0, 1'b1}));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      tick(vt[i].pe, vt[i].pe);
      check($sformatf("vec%0d", i),
            64'({if0.x, if0.y, if0.line_start, if0.frame_start, if0.fetch_x, if0.fetch_active, if0.hsync}),
            64'({10'(vt[i].x), 10'(vt[i].y), vt[i].ls, vt[i].fs, 10'(vt[i].fx), vt[i].fact, vt[i].hs}));
    end

    // Line timing on the full-size instance.
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick(1'b1, 1'b1);
      if (if0.line_start) ok = 1'b1;
    end
    check("wait_line_start", 64'(ok), 64'd1);
    hs_low = 0; act_cnt = 0; first_lo = -1; last_lo = -1; ls_at = -1;
    for (int i = 1; i <= 800; i++) begin
      tick(1'b1, 1'b1);
      if (!if0.hsync) begin
        hs_low++;
        if (first_lo < 0) first_lo = int'(if0.x);
        last_lo = int'(if0.x);
      end
      if (if0.active) act_cnt++;
      if (if0.line_start && ls_at < 0) ls_at = i;
    end
    check("hsync_low_clks", 64'(hs_low), 64'd96);
    check("hsync_first_x", 64'(first_lo), 64'd656);
    check("hsync_last_x", 64'(last_lo), 64'd751);
    check("active_per_line", 64'(act_cnt), 64'd640);
    check("line_period", 64'(ls_at), 64'd800);

    // Frame timing on the shrunken instance (16x12 raster, 192 clks per frame).
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick(1'b1, 1'b1);
      if (if1.frame_start) ok = 1'b1;
    end
    check("wait_frame_start", 64'(ok), 64'd1);
    vs_low = 0; act_cnt = 0; fs_at = -1;
    prev = get_obs(1);
    for (int i = 1; i <= 192; i++) begin
      tick(1'b1, 1'b1);
      cur = get_obs(1);
      if (!cur.vs) vs_low++;
      if (cur.act) act_cnt++;
      if (cur.fs && fs_at < 0) begin
        fs_at = i;
        check("wrap_from", 64'({prev.x, prev.y}), 64'({10'd15, 10'd11}));
        check("wrap_to", 64'({cur.x, cur.y}), 64'({10'd0, 10'd0}));
      end
      prev = cur;
    end
    check("vsync_low_clks", 64'(vs_low), 64'd32);
    check("active_per_frame", 64'(act_cnt), 64'd48);
    check("frame_period", 64'(fs_at), 64'd192);

    // 1-in-4 pixel enable.
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick(k % 4 == 0, k % 4 == 0);
      k++;
      if (if0.line_start) ok = 1'b1;
    end
    check("wait_line_start_q", 64'(ok), 64'd1);
    hs_low = 0; ls_cnt = 0; ls_at = -1; fs_prev = -1; fs_events = 0;
    for (int i = 1; i <= 3200; i++) begin
      tick(k % 4 == 0, k % 4 == 0);
      k++;
      if (!if0.hsync) hs_low++;
      if (if0.line_start) begin
        ls_cnt++;
        if (ls_at < 0) ls_at = i;
      end
      if (if1.frame_start) begin
        if (fs_prev >= 0) check("frame_period_q", 64'(i - fs_prev), 64'd768);
        fs_prev = i;
        fs_events++;
      end
    end
    check("hsync_low_q", 64'(hs_low), 64'd384);
    check("line_start_width_q", 64'(ls_cnt), 64'd1);
    check("line_period_q", 64'(ls_at), 64'd3200);
    check("frame_events_q", 64'(fs_events >= 3), 64'd1);

    // Asynchronous reset in the middle of hsync.
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick(1'b1, 1'b1);
      if (if0.x == 10'd700) ok = 1'b1;
    end
    check("reach_x700", 64'({ok, if0.hsync}), 64'({1'b1, 1'b0}));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset0", 64'({get_obs(0), get_fetch(0)}), 64'({reset_obs(), 10'd0, 10'd0, 1'b1}));
    check("async_reset1", 64'({get_obs(1), get_fetch(1)}), 64'({reset_obs(), 10'd0, 10'd0, 1'b1}));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    check("restart", 64'({if0.x, if0.y, if0.line_start, if0.frame_start}), 64'({10'd0, 10'd0, 1'b1, 1'b1}));
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
